// File: rtl/eth_rx_frame_ctrl.sv
// Receive-frame bookkeeping: synchronises receiver strobes, counts frame bytes and manages a
// two-slot FIFO of committed frames, dropping inhibited, runt, oversize or overflow frames.
`timescale 1ns/1ps
module eth_rx_frame_ctrl #(
  parameter int MIN_LEN = 14,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        n_recv_buf_we,
  input  logic        n_inhibit,
  output logic        recv_ena,
  output logic        buf_slot,
  output logic        rx_ready,
  output logic        rx_slot,
  output logic [10:0] rx_len,
  input  logic        rx_ack,
  output logic [7:0]  drop_cnt
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_SKIP   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RECV   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DROP   = 3'd4
  } state_t;

  logic [1:0]       ss_sync_q, ss_sync_d;
  logic [1:0]       we_sync_q, we_sync_d;
  logic [1:0]       inh_sync_q, inh_sync_d;
  logic             we_prev_q, we_prev_d;

  state_t           state_q, state_d;
  logic [10:0]      cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic [1:0]       full_q, full_d;
  logic [1:0][10:0] len_q, len_d;
  logic             buf_slot_q, buf_slot_d;
  logic             rx_slot_q, rx_slot_d;
  logic             recv_ena_q, recv_ena_d;
  logic             rx_ready_q, rx_ready_d;
  logic [10:0]      rx_len_q, rx_len_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             ss_s, inh_s, strobe_s, ack_s, frame_ok_s, drop_inc_s;

  assign ss_s       = ss_sync_q[1];
  assign inh_s      = inh_sync_q[1];
  assign strobe_s   = we_prev_q & ~we_sync_q[1];
  assign ack_s      = rx_ack & full_q[rx_slot_q];
  assign frame_ok_s = ~bad_q && (cnt_q >= MIN_L) && (cnt_q <= MAX_L);

  // Synchroniser next values; equal depth keeps the filter verdict ordered ahead of ss fall.
  always_comb begin
    ss_sync_d  = {ss_sync_q[0], ss};
    we_sync_d  = {we_sync_q[0], n_recv_buf_we};
    inh_sync_d = {inh_sync_q[0], n_inhibit};
    we_prev_d  = we_sync_q[1];
  end

  // Synchroniser flops are left unreset so a frame still in flight across rst is seen by SKIP.
  always_ff @(posedge clk) begin
    ss_sync_q  <= ss_sync_d;
    we_sync_q  <= we_sync_d;
    inh_sync_q <= inh_sync_d;
    we_prev_q  <= we_prev_d;
  end

  // Frame FSM, byte counter and slot queue next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    full_d     = full_q;
    len_d      = len_q;
    buf_slot_d = buf_slot_q;
    rx_slot_d  = rx_slot_q;
    drop_inc_s = 1'b0;

    if (ack_s) begin
      full_d[rx_slot_q] = 1'b0;
      rx_slot_d         = ~rx_slot_q;
    end else begin
      rx_slot_d = rx_slot_q;
    end

    case (state_q)
      ST_SKIP: begin
        if (!ss_s) state_d = ST_IDLE;
        else       state_d = ST_SKIP;
      end
      ST_IDLE: begin
        if (ss_s && recv_ena_q) begin
          state_d = ST_RECV;
          cnt_d   = 11'd0;
          bad_d   = 1'b0;
        end else if (ss_s) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        bad_d = bad_q | ~inh_s;
        if (strobe_s && (cnt_q != 11'h7FF)) cnt_d = cnt_q + 11'd1;
        else                                cnt_d = cnt_q;
        if (!ss_s) state_d = ST_COMMIT;
        else       state_d = ST_RECV;
      end
      ST_COMMIT: begin
        // The write slot is always empty here: recv_ena gated entry and only acks free slots.
        if (frame_ok_s) begin
          full_d[buf_slot_q] = 1'b1;
          len_d[buf_slot_q]  = cnt_q;
          buf_slot_d         = ~buf_slot_q;
        end else begin
          drop_inc_s = 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (!ss_s) begin
          drop_inc_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_SKIP;
    endcase
  end

  // Registered outputs derived from the next queue state.
  always_comb begin
    if (drop_inc_s && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    else                                     drop_cnt_d = drop_cnt_q;
    if ((state_d == ST_IDLE) || (state_d == ST_SKIP)) recv_ena_d = ~full_d[buf_slot_d];
    else                                              recv_ena_d = recv_ena_q;
    rx_ready_d = full_d[rx_slot_d];
    if (rx_ready_d) rx_len_d = len_d[rx_slot_d];
    else            rx_len_d = 11'd0;
  end

  // State and queue registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SKIP;
      cnt_q      <= 11'd0;
      bad_q      <= 1'b0;
      full_q     <= 2'b00;
      len_q      <= '0;
      buf_slot_q <= 1'b0;
      rx_slot_q  <= 1'b0;
      recv_ena_q <= 1'b1;
      rx_ready_q <= 1'b0;
      rx_len_q   <= 11'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      full_q     <= full_d;
      len_q      <= len_d;
      buf_slot_q <= buf_slot_d;
      rx_slot_q  <= rx_slot_d;
      recv_ena_q <= recv_ena_d;
      rx_ready_q <= rx_ready_d;
      rx_len_q   <= rx_len_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign recv_ena = recv_ena_q;
  assign buf_slot = buf_slot_q;
  assign rx_ready = rx_ready_q;
  assign rx_slot  = rx_slot_q;
  assign rx_len   = rx_len_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Self-checking bench for eth_rx_frame_ctrl: directed scenarios plus randomized frames
// compared against a FIFO-of-lengths reference model.
`timescale 1ns/1ps
module tb_eth_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, ss, n_recv_buf_we, n_inhibit, rx_ack;
  logic        recv_ena, buf_slot, rx_ready, rx_slot;
  logic [10:0] rx_len;
  logic [7:0]  drop_cnt;

  int tests_run = 0;
  int fails     = 0;

  int mq[$];
  int m_drop, m_commits, m_pops;

  eth_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .ss(ss), .n_recv_buf_we(n_recv_buf_we), .n_inhibit(n_inhibit),
    .recv_ena(recv_ena), .buf_slot(buf_slot), .rx_ready(rx_ready), .rx_slot(rx_slot),
    .rx_len(rx_len), .rx_ack(rx_ack), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    mq.delete();
    m_drop = 0; m_commits = 0; m_pops = 0;
  endtask

  task automatic m_frame(input int len, input bit inh);
    if (mq.size() == 2 || inh || len < 14 || len > 1518) begin
      if (m_drop < 255) m_drop++;
    end else begin
      mq.push_back(len);
      m_commits++;
    end
  endtask

  task automatic m_ack();
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      m_pops++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ss = 1'b0; n_recv_buf_we = 1'b1; n_inhibit = 1'b1; rx_ack = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(2);
    m_reset();
  endtask

  // Drives ss high, len byte strobes, then drops ss; inhibit goes low from byte inh_from (0 = never).
  task automatic drive_frame(input int len, input int inh_from);
    ss = 1'b1;
    tick(4);
    for (int i = 1; i <= len; i++) begin
      if (inh_from > 0 && i >= inh_from) n_inhibit = 1'b0;
      n_recv_buf_we = 1'b0; tick(2);
      n_recv_buf_we = 1'b1; tick(2);
    end
    tick(2);
    ss = 1'b0;
  endtask

  task automatic finish_frame();
    tick(6);
    n_inhibit = 1'b1;
    tick(2);
  endtask

  task automatic send_frame(input int len, input int inh_from);
    drive_frame(len, inh_from);
    finish_frame();
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1; tick(1);
    rx_ack = 1'b0; tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({recv_ena, buf_slot, rx_ready, rx_slot, rx_len, drop_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_state: got ena=%b bs=%b rdy=%b rs=%b len=%0d drop=%0d, expected 1 0 0 0 0 0",
               recv_ena, buf_slot, rx_ready, rx_slot, rx_len, drop_cnt);
    end
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    drive_frame(60, 0);
    lat = 0;
    for (int c = 1; c <= 4 && rx_ready !== 1'b1; c++) begin
      tick(1);
      lat = c;
    end
    tests_run++;
    if (rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL commit_latency: rx_ready=%b after %0d clk, expected 1 within 4", rx_ready, lat);
    end
    tests_run++;
    if ({rx_len, rx_slot, buf_slot} !== {11'd60, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL single_frame: got len=%0d rs=%b bs=%b, expected 60 0 1", rx_len, rx_slot, buf_slot);
    end
    finish_frame();
  endtask

  task automatic test_inhibit();
    do_reset();
    send_frame(60, 2);
    tests_run++;
    if ({rx_ready, drop_cnt, buf_slot} !== {1'b0, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL inhibit_drop: got rdy=%b drop=%0d bs=%b, expected 0 1 0", rx_ready, drop_cnt, buf_slot);
    end
  endtask

  task automatic test_queue_full();
    do_reset();
    send_frame(64, 0);
    send_frame(64, 0);
    tests_run++;
    if (recv_ena !== 1'b0) begin
      fails++;
      $display("FAIL queue_full_ena: got recv_ena=%b, expected 0", recv_ena);
    end
    send_frame(64, 0);
    tests_run++;
    if ({drop_cnt, rx_ready, rx_slot} !== {8'd1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL overflow_drop: got drop=%0d rdy=%b rs=%b, expected 1 1 0", drop_cnt, rx_ready, rx_slot);
    end
    pulse_ack();
    tests_run++;
    if ({rx_ready, rx_len, rx_slot, recv_ena} !== {1'b1, 11'd64, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL ack_frees_slot: got rdy=%b len=%0d rs=%b ena=%b, expected 1 64 1 1",
               rx_ready, rx_len, rx_slot, recv_ena);
    end
  endtask

  task automatic test_len_drop();
    do_reset();
    send_frame(10, 0);
    send_frame(1600, 0);
    tests_run++;
    if ({drop_cnt, rx_ready} !== {8'd2, 1'b0}) begin
      fails++;
      $display("FAIL runt_oversize: got drop=%0d rdy=%b, expected 2 0", drop_cnt, rx_ready);
    end
  endtask

  task automatic test_len_bounds();
    do_reset();
    send_frame(13, 0);
    send_frame(14, 0);
    tests_run++;
    if ({drop_cnt, rx_ready, rx_len} !== {8'd1, 1'b1, 11'd14}) begin
      fails++;
      $display("FAIL min_len: got drop=%0d rdy=%b len=%0d, expected 1 1 14", drop_cnt, rx_ready, rx_len);
    end
    pulse_ack();
    send_frame(1518, 0);
    tests_run++;
    if ({rx_ready, rx_len, rx_slot} !== {1'b1, 11'd1518, 1'b1}) begin
      fails++;
      $display("FAIL max_len: got rdy=%b len=%0d rs=%b, expected 1 1518 1", rx_ready, rx_len, rx_slot);
    end
    pulse_ack();
    send_frame(1519, 0);
    tests_run++;
    if ({drop_cnt, rx_ready} !== {8'd2, 1'b0}) begin
      fails++;
      $display("FAIL max_len_plus1: got drop=%0d rdy=%b, expected 2 0", drop_cnt, rx_ready);
    end
  endtask

  task automatic test_rst_mid_frame();
    do_reset();
    ss = 1'b1;
    tick(4);
    for (int i = 1; i <= 60; i++) begin
      n_recv_buf_we = 1'b0;
      if (i == 20) begin
        rst = 1'b1; tick(1);
        rst = 1'b0; tick(1);
      end else begin
        tick(2);
      end
      n_recv_buf_we = 1'b1; tick(2);
    end
    tick(2);
    ss = 1'b0;
    finish_frame();
    tests_run++;
    if ({rx_ready, drop_cnt} !== {1'b0, 8'd0}) begin
      fails++;
      $display("FAIL rst_mid_frame: got rdy=%b drop=%0d, expected 0 0", rx_ready, drop_cnt);
    end
    send_frame(60, 0);
    tests_run++;
    if ({rx_ready, rx_len, rx_slot} !== {1'b1, 11'd60, 1'b0}) begin
      fails++;
      $display("FAIL after_rst_frame: got rdy=%b len=%0d rs=%b, expected 1 60 0", rx_ready, rx_len, rx_slot);
    end
  endtask

  task automatic test_ack_commit();
    do_reset();
    send_frame(60, 0);
    drive_frame(40, 0);
    tick(3);
    rx_ack = 1'b1; tick(1);
    rx_ack = 1'b0;
    tick(4);
    n_inhibit = 1'b1;
    tick(2);
    tests_run++;
    if ({rx_ready, rx_slot, rx_len, buf_slot, recv_ena} !== {1'b1, 1'b1, 11'd40, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL ack_with_commit: got rdy=%b rs=%b len=%0d bs=%b ena=%b, expected 1 1 40 0 1",
               rx_ready, rx_slot, rx_len, buf_slot, recv_ena);
    end
    pulse_ack();
    tests_run++;
    if ({rx_ready, rx_slot, drop_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL ack_drains: got rdy=%b rs=%b drop=%0d, expected 0 0 0", rx_ready, rx_slot, drop_cnt);
    end
  endtask

  task automatic test_drop_sat();
    do_reset();
    for (int i = 1; i <= 258; i++) begin
      ss = 1'b1; tick(4);
      ss = 1'b0; tick(5);
      if (i == 100) begin
        tests_run++;
        if (drop_cnt !== 8'd100) begin
          fails++;
          $display("FAIL drop_count: got %0d, expected 100", drop_cnt);
        end
      end
    end
    tests_run++;
    if (drop_cnt !== 8'd255) begin
      fails++;
      $display("FAIL drop_saturate: got %0d, expected 255", drop_cnt);
    end
  endtask

  task automatic test_random();
    logic [22:0] got, exp;
    int len, inh_from;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 13);
      else                           len = $urandom_range(14, 90);
      inh_from = 0;
      if (len > 0 && $urandom_range(0, 3) == 0) inh_from = $urandom_range(1, len);
      send_frame(len, inh_from);
      m_frame(len, inh_from > 0);
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 1) begin
          if ($urandom_range(0, 2) == 0) break;
          pulse_ack();
          m_ack();
        end
        exp = {1'(mq.size() < 2), 1'(m_commits % 2), 1'(mq.size() > 0), 1'(m_pops % 2),
               (mq.size() > 0) ? 11'(mq[0]) : 11'd0, 8'(m_drop)};
        got = {recv_ena, buf_slot, rx_ready, rx_slot, rx_len, drop_cnt};
        tests_run++;
        if (got !== exp) begin
          fails++;
          $display("FAIL random_it%0d_ph%0d: got ena/bs/rdy/rs/len/drop=%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%0d/%0d",
                   it, ph, got[22], got[21], got[20], got[19], got[18:8], got[7:0],
                   exp[22], exp[21], exp[20], exp[19], exp[18:8], exp[7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_inhibit();
    test_queue_full();
    test_len_drop();
    test_len_bounds();
    test_rst_mid_frame();
    test_ack_commit();
    test_drop_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
